// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM states and special-case result constants for md_unit
package md_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [XLEN-1:0] DZ_QUOTIENT   = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_DIVIDEND  = 32'h8000_0000;
    localparam logic [XLEN-1:0] OVF_QUOTIENT  = 32'h8000_0000;
    localparam logic [XLEN-1:0] OVF_REMAINDER = 32'h0000_0000;

endpackage

// File: rtl/md_if.sv
// rtl/md_if.sv - EX-stage request/response bundle between the pipeline and md_unit
interface md_if;
    import md_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            stall_req;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, kill,
        input  stall_req, busy, done, result
    );

    modport slave (
        input  start, op, a, b, kill,
        output stall_req, busy, done, result
    );

endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
// MD_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply finish in one cycle
module md_unit
    import md_pkg::*;
(
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    md_state_e           state, state_nx;
    logic [4:0]          cnt;
    logic [2:0]          op_r;
    logic                sa_r, sb_r, dz_r;
    logic [XLEN-1:0]     mb_r;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     result_r;

    logic                accept, last_step, early;
    logic                signed_a, signed_b, sa_in, sb_in, dz_in;
    logic [XLEN-1:0]     ma_in, mb_in;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_sh;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   step_next, prod;
    logic                neg;
    logic [XLEN-1:0]     quo, rem, fin;

    assign accept    = (state == ST_IDLE) && md.start && !md.kill;
    assign last_step = (state == ST_BUSY) && (cnt == 5'd31);

    assign signed_a = (md.op == MD_MULH) || (md.op == MD_MULHSU) ||
                      (md.op == MD_DIV)  || (md.op == MD_REM);
    assign signed_b = (md.op == MD_MULH) || (md.op == MD_DIV) || (md.op == MD_REM);
    assign sa_in    = signed_a && md.a[XLEN-1];
    assign sb_in    = signed_b && md.b[XLEN-1];
    // 0x80000000 negates to itself, which is exactly its unsigned magnitude
    assign ma_in    = sa_in ? -md.a : md.a;
    assign mb_in    = sb_in ? -md.b : md.b;
    assign dz_in    = md.op[2] && (md.b == '0);

`ifdef MD_EARLY_OUT_EN
    logic            ovf_in;
    logic [XLEN-1:0] early_val;

    assign ovf_in = ((md.op == MD_DIV) || (md.op == MD_REM)) &&
                    (md.a == OVF_DIVIDEND) && (md.b == '1);
    assign early  = dz_in || ovf_in || (!md.op[2] && ((md.a == '0) || (md.b == '0)));

    always_comb begin
        early_val = '0;
        if (dz_in)
            early_val = md.op[1] ? md.a : DZ_QUOTIENT;
        else if (ovf_in)
            early_val = md.op[1] ? OVF_REMAINDER : OVF_QUOTIENT;
    end
`else
    assign early = 1'b0;
`endif

    // acc = {hi, lo}: multiply shifts right adding mb into hi; divide shifts left into a restoring remainder
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb_r} : '0);
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, mb_r});
        div_diff = div_sh[XLEN-1:0] - mb_r;
        if (op_r[2])
            step_next = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
        else
            step_next = {mul_sum, acc[XLEN-1:1]};
    end

    always_comb begin
        neg  = sa_r ^ sb_r;
        prod = neg ? -step_next : step_next;
        quo  = dz_r ? DZ_QUOTIENT : (neg ? -step_next[XLEN-1:0] : step_next[XLEN-1:0]);
        rem  = sa_r ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
        case (op_r)
            MD_MUL:                       fin = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fin = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fin = quo;
            default:                      fin = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = early ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_step) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (md.kill)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            op_r     <= '0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            dz_r     <= 1'b0;
            mb_r     <= '0;
            acc      <= '0;
            result_r <= '0;
        end else if (accept) begin
            cnt  <= '0;
            op_r <= md.op;
            sa_r <= sa_in;
            sb_r <= sb_in;
            dz_r <= dz_in;
            mb_r <= mb_in;
            acc  <= {{XLEN{1'b0}}, ma_in};
`ifdef MD_EARLY_OUT_EN
            if (early)
                result_r <= early_val;
`endif
        end else if ((state == ST_BUSY) && !md.kill) begin
            acc <= step_next;
            cnt <= cnt + 5'd1;
            if (last_step)
                result_r <= fin;
        end
    end

    assign md.stall_req = accept || (state == ST_BUSY);
    assign md.busy      = (state == ST_BUSY);
    assign md.done      = (state == ST_DONE);
    assign md.result    = result_r;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit: directed corner cases plus randomized ops vs a reference model
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;
    md_if mdi ();

    md_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY_CFG = 1'b1;
`else
    localparam bit EARLY_CFG = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            MD_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            MD_MULH:   begin xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; p = xa * xb; return p[63:32]; end
            MD_MULHSU: begin xa = {{32{a[31]}}, a}; xb = {32'b0, b}; p = xa * xb; return p[63:32]; end
            MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return EARLY_CFG && ((op[2] && b == 0) ||
                             ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                             (!op[2] && (a == 0 || b == 0)));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // monitor: every done pops one expected result
    always @(negedge clk) begin
        if (!reset && mdi.done) begin
            if (exp_q.size() == 0)
                check("unexpected_done", {31'b0, mdi.done}, 32'h0);
            else
                check("result", mdi.result, exp_q.pop_front());
        end
    end

    task automatic run_op(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] exp_v);
        int stalls, busys;
        bit got, early;
        early = is_early(op_v, a_v, b_v);
        @(negedge clk);
        mdi.start = 1'b1;
        mdi.op    = op_v;
        mdi.a     = a_v;
        mdi.b     = b_v;
        exp_q.push_back(exp_v);
        #1;
        check("accept_busy_low", {31'b0, mdi.busy}, 32'h0);
        stalls = 0;
        busys  = 0;
        got    = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (mdi.done) begin
                got = 1'b1;
                break;
            end
            stalls += int'(mdi.stall_req);
            busys  += int'(mdi.busy);
            @(negedge clk);
            #1;
        end
        mdi.start = 1'b0;
        check("done_seen", {31'b0, got}, 32'h1);
        check("stall_cycles", stalls, early ? 32'd1 : 32'd33);
        check("busy_cycles", busys, early ? 32'd0 : 32'd32);
        check("done_stall_low", {31'b0, mdi.stall_req}, 32'h0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset     = 1'b1;
        mdi.start = 1'b0;
        mdi.op    = '0;
        mdi.a     = '0;
        mdi.b     = '0;
        mdi.kill  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'b0, mdi.stall_req}, 32'h0);
        check("rst_busy", {31'b0, mdi.busy}, 32'h0);
        check("rst_done", {31'b0, mdi.done}, 32'h0);
        check("rst_result", mdi.result, 32'h0);
        reset = 1'b0;

        run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op(MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF);
        run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0);
        run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op(MD_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);
        run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);

        // start together with kill in IDLE must not be accepted
        @(negedge clk);
        mdi.start = 1'b1;
        mdi.kill  = 1'b1;
        mdi.op    = MD_MUL;
        mdi.a     = 32'd5;
        mdi.b     = 32'd6;
        #1;
        check("idle_kill_stall", {31'b0, mdi.stall_req}, 32'h0);
        @(negedge clk);
        mdi.start = 1'b0;
        mdi.kill  = 1'b0;
        #1;
        check("idle_kill_busy", {31'b0, mdi.busy}, 32'h0);

        // kill at BUSY cycle 10
        @(negedge clk);
        mdi.start = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        check("kill_in_busy", {31'b0, mdi.busy}, 32'h1);
        mdi.kill = 1'b1;
        @(negedge clk);
        mdi.kill  = 1'b0;
        mdi.start = 1'b0;
        #1;
        check("kill_busy", {31'b0, mdi.busy}, 32'h0);
        check("kill_stall", {31'b0, mdi.stall_req}, 32'h0);
        check("kill_done", {31'b0, mdi.done}, 32'h0);
        repeat (40) @(negedge clk);
        run_op(MD_MUL, 32'd3, 32'd4, 32'd12);

        // reset in the middle of a divide
        @(negedge clk);
        mdi.start = 1'b1;
        mdi.op    = MD_DIV;
        mdi.a     = 32'd1000;
        mdi.b     = 32'd3;
        repeat (6) @(negedge clk);
        reset     = 1'b1;
        mdi.start = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_stall", {31'b0, mdi.stall_req}, 32'h0);
        check("mid_rst_busy", {31'b0, mdi.busy}, 32'h0);
        check("mid_rst_done", {31'b0, mdi.done}, 32'h0);
        check("mid_rst_result", mdi.result, 32'h0);
        reset = 1'b0;

        run_op(MD_DIVU, 32'd100, 32'd7, 32'd14);
        run_op(MD_DIVU, 32'd100, 32'd9, 32'd11);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op(rop, ra, rb, ref_md(rop, ra, rb));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operation, operands and valid qualifier held in the ID/EX pipeline register. It produces the stall request that holds that register, IF and ID until the result is ready. One operation is in flight at a time. The result is returned on the single cycle in which the instruction is released to EX/MEM.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  a valid M-extension instruction is in EX (ID/EX output decoded, not a bubble).
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  32  rs1 operand, already forwarded.
- b  input  32  rs2 operand, already forwarded.
- kill  input  1  flush of the EX instruction (branch/jump redirect from older stage); abort.
- stall_req  output  1  hold ID/EX (drives ~en), IF and ID.
- busy  output  1  unit is in BUSY state.
- done  output  1  result valid this cycle; instruction advances.
- result  output  32  rd value, valid only while done=1.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: accepts when start=1 and kill=0.
  - Latches op, operand signs, magnitudes and cnt=0.
  - Goes to BUSY.
- BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle on a 64-bit accumulator; cnt increments.
  - After the step with cnt=31, applies the sign fix and writes the result register.
  - Goes to DONE.
- DONE: done=1 for exactly one cycle; start is ignored; always returns to IDLE.
- stall_req = (IDLE & start & ~kill) | BUSY. It is 0 in DONE, so the instruction leaves EX on the DONE edge.
- kill, in any state, forces IDLE on the next edge with no done. kill has priority over start and over completion.
- reset: same effect as kill. All outputs reset to 0: stall_req=0, busy=0, done=0, result=0, cnt=0.
- Signedness:
  - MULH: signed×signed.
  - MULHSU: signed a × unsigned b.
  - MULHU and DIVU/REMU: unsigned.
  - MUL returns product[31:0]; MULH* return product[63:32].
  - Product is negated when sign(a)^sign(b) for the signed operand kinds.
  - Quotient sign is sa^sb; remainder sign is sa.
- Divide-by-zero (b=0):
  - DIV/DIVU result 0xFFFFFFFF.
  - REM/REMU result a.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF):
  - quotient 0x80000000.
  - REM result 0.
- Operand magnitude of 0x80000000 is handled at 33-bit internal width; no truncation.

## Timing
- Normal latency: accept edge, then 32 BUSY cycles, then 1 DONE cycle.
- The instruction occupies EX for 34 cycles; stall_req is high for 33 of them.
- done and result come from registers; no combinational path from a/b to result.
- stall_req depends combinationally on start and kill. The hazard unit must OR it into StallF/StallD/~en without a loop through kill.
- Back-to-back M instructions: IDLE follows DONE. The next op is accepted the cycle after DONE, with no lost cycle beyond that.

## Configuration
- MD_EARLY_OUT_EN defined: these cases go IDLE→DONE directly, for a latency of 1 cycle (done in the cycle after accept):
  - divide-by-zero;
  - signed overflow;
  - multiply with a=0 or b=0.
  - busy is never asserted for them.
- MD_EARLY_OUT_EN undefined: every operation takes the full 32 BUSY cycles. Results are identical in both configurations.

## Structure
- Shared package md_pkg holds:
  - the funct3 op constants (MD_MUL … MD_REMU);
  - the state encoding (IDLE/BUSY/DONE);
  - the divide-by-zero and overflow result constants.
- Single module, no sub-module: the FSM, counter, 64-bit accumulator and sign-fix logic share one register set. The ALU's funct3 decode reuses the md_pkg constants.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD) → stall_req high 33 cycles, then done=1 with result=0xFFFFFFEB.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → result=0xFFFFFFFE. MULHSU with a=-1 and b=0xFFFFFFFF → result=0xFFFFFFFF.
- DIV a=-7, b=2 → result=0xFFFFFFFD; REM with the same operands → result=0xFFFFFFFF.
- DIVU a=5, b=0 → 0xFFFFFFFF. REM a=0x80000000, b=-1 → 0. With MD_EARLY_OUT_EN, done arrives 1 cycle after accept and busy stays 0.
- kill asserted at BUSY cycle 10 → IDLE next edge, done never asserted. A new MUL 3×4 accepted afterwards → 12.
- reset asserted mid-BUSY → all outputs 0 next edge. Two consecutive DIVU ops (100/7, then 100/9) → 14 then 11, with exactly one IDLE cycle between them.
